// File: rtl/dallanma_cozucu.sv
// dallanma_cozucu: execute-stage branch resolution unit.
// Queues fetch-time predictions in program order, resolves each branch/jump
// in execute, and drives a registered predictor-update packet plus a
// redirect/flush on misprediction.
// Optional feature macro: DALLANMA_SAYAC_EN (correct/wrong prediction counters).
module dallanma_cozucu #(
  parameter int unsigned DERINLIK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        getir_dallanma_i,
  input  logic        getir_atladi_i,
  input  logic [31:0] getir_ongoru_i,
  output logic        getir_durdur_o,
  input  logic        yurut_gecerli_i,
  input  logic [1:0]  yurut_tur_i,
  input  logic [2:0]  yurut_funct3_i,
  input  logic [31:0] yurut_ps_i,
  input  logic [31:0] yurut_rs1_i,
  input  logic [31:0] yurut_rs2_i,
  input  logic [31:0] yurut_imm_i,
  output logic        guncelle_o,
  output logic        atladi_o,
  output logic [31:0] ps_o,
  output logic [31:0] atlanan_adres_o,
  output logic        hatali_tahmin_o,
  output logic        yonlendir_o,
  output logic [31:0] yonlendir_adres_o,
  output logic [31:0] dogru_sayac_o,
  output logic [31:0] yanlis_sayac_o
);

  localparam int unsigned PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] TUR_KOSUL = 2'b00;
  localparam logic [1:0] TUR_JAL   = 2'b01;
  localparam logic [1:0] TUR_JALR  = 2'b10;
  localparam logic [1:0] TUR_AYRIK = 2'b11;

  // Prediction storage: {predicted taken, predicted target}
  logic [32:0]   mem [DERINLIK];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] doluluk;

  logic          bos;
  logic          dolu;
  logic          pop;
  logic          push_ok;
  logic          tahmin_atladi;
  logic [31:0]   tahmin_hedef;
  logic          gercek_atladi;
  logic [31:0]   gercek_hedef;
  logic          kosul;
  logic [31:0]   ps_hedef;
  logic [31:0]   jalr_hedef;
  logic [31:0]   sonraki_ps;
  logic          guncelle_c;
  logic          hatali_c;
  logic [31:0]   yonlendir_adres_c;

  // Occupancy flags; stall is combinational from occupancy
  always_comb begin
    bos  = (doluluk == '0);
    dolu = (doluluk == CW'(DERINLIK));
  end

  assign getir_durdur_o = dolu;

  // Branch condition evaluation by funct3
  always_comb begin
    kosul = 1'b0;
    case (yurut_funct3_i)
      3'b000:  kosul = (yurut_rs1_i == yurut_rs2_i);
      3'b001:  kosul = (yurut_rs1_i != yurut_rs2_i);
      3'b100:  kosul = ($signed(yurut_rs1_i) <  $signed(yurut_rs2_i));
      3'b101:  kosul = ($signed(yurut_rs1_i) >= $signed(yurut_rs2_i));
      3'b110:  kosul = (yurut_rs1_i <  yurut_rs2_i);
      3'b111:  kosul = (yurut_rs1_i >= yurut_rs2_i);
      default: kosul = 1'b0;
    endcase
  end

  // Resolve the head entry against the actual outcome
  always_comb begin
    pop           = yurut_gecerli_i && !bos;
    tahmin_atladi = mem[rd_ptr][32];
    tahmin_hedef  = mem[rd_ptr][31:0];
    ps_hedef      = yurut_ps_i + yurut_imm_i;
    jalr_hedef    = (yurut_rs1_i + yurut_imm_i) & 32'hFFFF_FFFE;
    sonraki_ps    = yurut_ps_i + 32'd4;
    gercek_atladi = 1'b0;
    gercek_hedef  = ps_hedef;
    case (yurut_tur_i)
      TUR_KOSUL: gercek_atladi = kosul;
      TUR_JAL:   gercek_atladi = 1'b1;
      TUR_JALR: begin
        gercek_atladi = 1'b1;
        gercek_hedef  = jalr_hedef;
      end
      default:   gercek_atladi = 1'b0;
    endcase
    guncelle_c = pop && (yurut_tur_i != TUR_AYRIK);
    hatali_c   = guncelle_c &&
                 ((gercek_atladi != tahmin_atladi) ||
                  (gercek_atladi && (gercek_hedef != tahmin_hedef)));
    yonlendir_adres_c = gercek_atladi ? gercek_hedef : sonraki_ps;
    // A push is dropped on flush (wrong path) and when full without a pop
    push_ok = getir_dallanma_i && !hatali_c && (!dolu || pop);
  end

  // FIFO pointers and occupancy; a misprediction empties the queue
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      doluluk <= '0;
    end else if (hatali_c) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      doluluk <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (push_ok && !pop)      doluluk <= doluluk + CW'(1);
      else if (!push_ok && pop) doluluk <= doluluk - CW'(1);
    end
  end

  // Prediction storage write; contents need no reset since occupancy guards reads
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= {getir_atladi_i, getir_ongoru_i};
  end

  // Registered update packet and redirect; data fields hold between strobes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      guncelle_o        <= 1'b0;
      atladi_o          <= 1'b0;
      ps_o              <= '0;
      atlanan_adres_o   <= '0;
      hatali_tahmin_o   <= 1'b0;
      yonlendir_o       <= 1'b0;
      yonlendir_adres_o <= '0;
    end else begin
      guncelle_o      <= guncelle_c;
      hatali_tahmin_o <= hatali_c;
      yonlendir_o     <= hatali_c;
      if (guncelle_c) begin
        atladi_o          <= gercek_atladi;
        ps_o              <= yurut_ps_i;
        atlanan_adres_o   <= gercek_hedef;
        yonlendir_adres_o <= yonlendir_adres_c;
      end
    end
  end

`ifdef DALLANMA_SAYAC_EN
  logic [31:0] dogru_q;
  logic [31:0] yanlis_q;

  // Prediction accuracy counters, wrapping naturally at 2^32
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dogru_q  <= '0;
      yanlis_q <= '0;
    end else if (guncelle_c) begin
      if (hatali_c) yanlis_q <= yanlis_q + 32'd1;
      else          dogru_q  <= dogru_q + 32'd1;
    end
  end

  assign dogru_sayac_o  = dogru_q;
  assign yanlis_sayac_o = yanlis_q;
`else
  assign dogru_sayac_o  = '0;
  assign yanlis_sayac_o = '0;
`endif

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Self-checking bench for dallanma_cozucu: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_dallanma_cozucu;

  localparam int unsigned DERINLIK = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        getir_dallanma_i;
  logic        getir_atladi_i;
  logic [31:0] getir_ongoru_i;
  logic        getir_durdur_o;
  logic        yurut_gecerli_i;
  logic [1:0]  yurut_tur_i;
  logic [2:0]  yurut_funct3_i;
  logic [31:0] yurut_ps_i, yurut_rs1_i, yurut_rs2_i, yurut_imm_i;
  logic        guncelle_o, atladi_o, hatali_tahmin_o, yonlendir_o;
  logic [31:0] ps_o, atlanan_adres_o, yonlendir_adres_o;
  logic [31:0] dogru_sayac_o, yanlis_sayac_o;

  dallanma_cozucu #(.DERINLIK(DERINLIK)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .getir_dallanma_i(getir_dallanma_i), .getir_atladi_i(getir_atladi_i),
    .getir_ongoru_i(getir_ongoru_i), .getir_durdur_o(getir_durdur_o),
    .yurut_gecerli_i(yurut_gecerli_i), .yurut_tur_i(yurut_tur_i),
    .yurut_funct3_i(yurut_funct3_i), .yurut_ps_i(yurut_ps_i),
    .yurut_rs1_i(yurut_rs1_i), .yurut_rs2_i(yurut_rs2_i), .yurut_imm_i(yurut_imm_i),
    .guncelle_o(guncelle_o), .atladi_o(atladi_o), .ps_o(ps_o),
    .atlanan_adres_o(atlanan_adres_o), .hatali_tahmin_o(hatali_tahmin_o),
    .yonlendir_o(yonlendir_o), .yonlendir_adres_o(yonlendir_adres_o),
    .dogru_sayac_o(dogru_sayac_o), .yanlis_sayac_o(yanlis_sayac_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic t; logic [31:0] a; } tahmin_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  tahmin_t     q[$];
  logic        e_guncelle, e_atladi, e_hatali;
  logic [31:0] e_ps, e_adres, e_yadres, e_dogru, e_yanlis;

  task automatic model_reset();
    q.delete();
    e_guncelle = 0; e_atladi = 0; e_hatali = 0;
    e_ps = 0; e_adres = 0; e_yadres = 0; e_dogru = 0; e_yanlis = 0;
  endtask

  // One clock of the architectural rules, applied to the inputs held at the edge
  task automatic model_step();
    logic    taken;
    logic [31:0] hedef;
    logic    was_full, popped;
    tahmin_t p;
    was_full = (q.size() == DERINLIK);
    popped = 0;
    e_guncelle = 0; e_hatali = 0;
    if (yurut_gecerli_i && q.size() > 0) begin
      p = q.pop_front();
      popped = 1;
      if (yurut_tur_i != 2'b11) begin
        hedef = yurut_ps_i + yurut_imm_i;
        taken = 1;
        if (yurut_tur_i == 2'b00) begin
          case (yurut_funct3_i)
            3'd0: taken = (yurut_rs1_i == yurut_rs2_i);
            3'd1: taken = (yurut_rs1_i != yurut_rs2_i);
            3'd4: taken = ($signed(yurut_rs1_i) < $signed(yurut_rs2_i));
            3'd5: taken = !($signed(yurut_rs1_i) < $signed(yurut_rs2_i));
            3'd6: taken = (yurut_rs1_i < yurut_rs2_i);
            3'd7: taken = !(yurut_rs1_i < yurut_rs2_i);
            default: taken = 0;
          endcase
        end else if (yurut_tur_i == 2'b10) begin
          hedef = yurut_rs1_i + yurut_imm_i;
          hedef[0] = 1'b0;
        end
        e_guncelle = 1;
        e_atladi = taken;
        e_ps = yurut_ps_i;
        e_adres = hedef;
        e_yadres = taken ? hedef : yurut_ps_i + 4;
        e_hatali = (taken != p.t) || (taken && p.t && hedef != p.a);
        if (e_hatali) begin
          q.delete();
          e_yanlis = e_yanlis + 1;
        end else begin
          e_dogru = e_dogru + 1;
        end
      end
    end
    if (getir_dallanma_i && !e_hatali && (!was_full || popped))
      q.push_back({getir_atladi_i, getir_ongoru_i});
  endtask

  function automatic logic [31:0] exp_dogru();
`ifdef DALLANMA_SAYAC_EN
    return e_dogru;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_yanlis();
`ifdef DALLANMA_SAYAC_EN
    return e_yanlis;
`else
    return 32'd0;
`endif
  endfunction

  task automatic idle();
    getir_dallanma_i = 0; getir_atladi_i = 0; getir_ongoru_i = 0;
    yurut_gecerli_i = 0; yurut_tur_i = 0; yurut_funct3_i = 0;
    yurut_ps_i = 0; yurut_rs1_i = 0; yurut_rs2_i = 0; yurut_imm_i = 0;
  endtask

  task automatic set_push(input logic t, input logic [31:0] a);
    getir_dallanma_i = 1; getir_atladi_i = t; getir_ongoru_i = a;
  endtask

  task automatic set_resolve(input logic [1:0] tur, input logic [2:0] f3,
                             input logic [31:0] ps, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] imm);
    yurut_gecerli_i = 1; yurut_tur_i = tur; yurut_funct3_i = f3;
    yurut_ps_i = ps; yurut_rs1_i = r1; yurut_rs2_i = r2; yurut_imm_i = imm;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    model_step();
    idle();
  endtask

  task automatic test_reset();
    rst_i = 0;
    idle();
    model_reset();
    #12;
    checks++;
    if ({guncelle_o, atladi_o, hatali_tahmin_o, yonlendir_o, getir_durdur_o} !== 5'b0 ||
        ps_o !== 0 || atlanan_adres_o !== 0 || yonlendir_adres_o !== 0 ||
        dogru_sayac_o !== 0 || yanlis_sayac_o !== 0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero (ps=%h adr=%h yadr=%h strobes=%b)",
               ps_o, atlanan_adres_o, yonlendir_adres_o,
               {guncelle_o, atladi_o, hatali_tahmin_o, yonlendir_o, getir_durdur_o});
    end
    @(negedge clk_i);
    rst_i = 1;
  endtask

  task automatic test_correct();
    set_push(1, 32'h100); tick();
    set_resolve(2'b00, 3'b000, 32'hF0, 5, 5, 32'h10); tick();
    checks++;
    if (guncelle_o !== 1 || atladi_o !== 1 || atlanan_adres_o !== 32'h100 ||
        hatali_tahmin_o !== 0 || yonlendir_o !== 0) begin
      errors++;
      $display("FAIL correct_beq: got upd=%b tk=%b adr=%h mis=%b rd=%b, want 1 1 00000100 0 0",
               guncelle_o, atladi_o, atlanan_adres_o, hatali_tahmin_o, yonlendir_o);
    end
    checks++;
    if (dogru_sayac_o !== exp_dogru() || yanlis_sayac_o !== exp_yanlis()) begin
      errors++;
      $display("FAIL correct_counters: got %0d/%0d want %0d/%0d",
               dogru_sayac_o, yanlis_sayac_o, exp_dogru(), exp_yanlis());
    end
    tick();
    checks++;
    if (guncelle_o !== 0 || atlanan_adres_o !== 32'h100) begin
      errors++;
      $display("FAIL pulse_hold: got upd=%b adr=%h want 0 00000100", guncelle_o, atlanan_adres_o);
    end
  endtask

  task automatic test_dir_mispredict();
    set_push(1, 32'h200); tick();
    set_resolve(2'b00, 3'b001, 32'h40, 7, 7, 32'h20); tick();
    checks++;
    if (hatali_tahmin_o !== 1 || yonlendir_o !== 1 || atladi_o !== 0 ||
        yonlendir_adres_o !== 32'h44) begin
      errors++;
      $display("FAIL dir_mispredict: got mis=%b rd=%b tk=%b yadr=%h want 1 1 0 00000044",
               hatali_tahmin_o, yonlendir_o, atladi_o, yonlendir_adres_o);
    end
    set_resolve(2'b01, 3'b000, 32'h40, 0, 0, 0); tick();
    checks++;
    if (guncelle_o !== 0) begin
      errors++;
      $display("FAIL dir_fifo_empty: got upd=%b want 0", guncelle_o);
    end
  endtask

  task automatic test_jalr();
    set_push(1, 32'h300); tick();
    set_resolve(2'b10, 3'b000, 32'h500, 32'h1001, 0, 32'h4); tick();
    checks++;
    if (atlanan_adres_o !== 32'h1004 || hatali_tahmin_o !== 1 ||
        yonlendir_adres_o !== 32'h1004) begin
      errors++;
      $display("FAIL jalr_target: got adr=%h mis=%b yadr=%h want 00001004 1 00001004",
               atlanan_adres_o, hatali_tahmin_o, yonlendir_adres_o);
    end
  endtask

  task automatic test_signed();
    set_push(1, 32'hC0); tick();
    set_push(0, 32'h0);  tick();
    set_resolve(2'b00, 3'b100, 32'h80, 32'hFFFF_FFFF, 1, 32'h40); tick();
    checks++;
    if (atladi_o !== 1 || hatali_tahmin_o !== 0 || guncelle_o !== 1) begin
      errors++;
      $display("FAIL blt_signed: got tk=%b mis=%b upd=%b want 1 0 1",
               atladi_o, hatali_tahmin_o, guncelle_o);
    end
    set_resolve(2'b00, 3'b110, 32'h80, 32'hFFFF_FFFF, 1, 32'h40); tick();
    checks++;
    if (atladi_o !== 0 || hatali_tahmin_o !== 0 || yonlendir_adres_o !== 32'h84) begin
      errors++;
      $display("FAIL bltu_unsigned: got tk=%b mis=%b yadr=%h want 0 0 00000084",
               atladi_o, hatali_tahmin_o, yonlendir_adres_o);
    end
    set_resolve(2'b00, 3'b000, 32'h90, 1, 1, 32'h8); tick();
    checks++;
    if (guncelle_o !== 0 || ps_o !== 32'h80) begin
      errors++;
      $display("FAIL pop_empty: got upd=%b ps=%h want 0 00000080", guncelle_o, ps_o);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_push(1, 32'h1000 + 32'(i) * 16); tick();
    end
    checks++;
    if (getir_durdur_o !== 1) begin
      errors++;
      $display("FAIL full_stall: got %b want 1", getir_durdur_o);
    end
    set_push(1, 32'h1040);
    set_resolve(2'b01, 3'b000, 32'h1000, 0, 0, 0); tick();
    checks++;
    if (getir_durdur_o !== 1 || guncelle_o !== 1 || hatali_tahmin_o !== 0) begin
      errors++;
      $display("FAIL full_push_pop: got stall=%b upd=%b mis=%b want 1 1 0",
               getir_durdur_o, guncelle_o, hatali_tahmin_o);
    end
    set_push(1, 32'hDEAD0000); tick();
    for (int k = 0; k < 4; k++) begin
      set_resolve(2'b01, 3'b000, 32'h1010 + 32'(k) * 16, 0, 0, 0); tick();
      checks++;
      if (guncelle_o !== 1 || hatali_tahmin_o !== 0 ||
          ps_o !== 32'h1010 + 32'(k) * 16 || getir_durdur_o !== 0) begin
        errors++;
        $display("FAIL full_order%0d: got upd=%b mis=%b ps=%h stall=%b",
                 k, guncelle_o, hatali_tahmin_o, ps_o, getir_durdur_o);
      end
    end
    set_push(0, 0); tick();
    set_push(0, 0); tick();
    set_push(1, 32'h4444);
    set_resolve(2'b01, 3'b000, 32'h10, 0, 0, 0); tick();
    checks++;
    if (hatali_tahmin_o !== 1 || getir_durdur_o !== 0) begin
      errors++;
      $display("FAIL flush_push: got mis=%b stall=%b want 1 0", hatali_tahmin_o, getir_durdur_o);
    end
    set_resolve(2'b01, 3'b000, 32'h3000, 0, 0, 32'h1444); tick();
    checks++;
    if (guncelle_o !== 0) begin
      errors++;
      $display("FAIL flush_empty: got upd=%b want 0", guncelle_o);
    end
  endtask

  task automatic test_reset_mid();
    set_push(1, 32'h700); tick();
    set_resolve(2'b01, 3'b000, 32'h600, 0, 0, 32'h100); tick();
    for (int i = 0; i < 3; i++) begin
      set_push(1, 32'h800); tick();
    end
    checks++;
    if (ps_o !== 32'h600 || atlanan_adres_o !== 32'h700) begin
      errors++;
      $display("FAIL pre_reset: got ps=%h adr=%h want 00000600 00000700", ps_o, atlanan_adres_o);
    end
    @(negedge clk_i);
    #2 rst_i = 0;
    #1;
    model_reset();
    checks++;
    if (ps_o !== 0 || atlanan_adres_o !== 0 || yonlendir_adres_o !== 0 || atladi_o !== 0 ||
        getir_durdur_o !== 0 || dogru_sayac_o !== 0 || yanlis_sayac_o !== 0) begin
      errors++;
      $display("FAIL reset_async: got ps=%h adr=%h yadr=%h tk=%b want all zero",
               ps_o, atlanan_adres_o, yonlendir_adres_o, atladi_o);
    end
    @(negedge clk_i);
    rst_i = 1;
    set_resolve(2'b01, 3'b000, 32'h700, 0, 0, 32'h100); tick();
    checks++;
    if (guncelle_o !== 0) begin
      errors++;
      $display("FAIL reset_discard: got upd=%b want 0", guncelle_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] vals [4];
    vals[0] = 0; vals[1] = 1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1)
        set_push(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0) ? 32'h140 : $urandom());
      if ($urandom_range(0, 2) != 0) begin
        set_resolve(($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                    3'($urandom()),
                    ($urandom_range(0, 4) != 0) ? 32'h100 : $urandom(),
                    ($urandom_range(0, 1) == 1) ? 32'h13F : vals[$urandom_range(0, 3)],
                    vals[$urandom_range(0, 3)],
                    ($urandom_range(0, 4) != 0) ? 32'h40 : 32'h1);
        if (yurut_tur_i == 2'b10) yurut_imm_i = 32'h1;
      end
      tick();
      checks++;
      if (guncelle_o !== e_guncelle || hatali_tahmin_o !== e_hatali ||
          yonlendir_o !== e_hatali || atladi_o !== e_atladi || ps_o !== e_ps ||
          atlanan_adres_o !== e_adres || yonlendir_adres_o !== e_yadres ||
          getir_durdur_o !== (q.size() == DERINLIK) ||
          dogru_sayac_o !== exp_dogru() || yanlis_sayac_o !== exp_yanlis()) begin
        errors++;
        $display("FAIL random%0d: got upd=%b mis=%b tk=%b ps=%h adr=%h yadr=%h stall=%b cnt=%0d/%0d want upd=%b mis=%b tk=%b ps=%h adr=%h yadr=%h stall=%b cnt=%0d/%0d",
                 n, guncelle_o, hatali_tahmin_o, atladi_o, ps_o, atlanan_adres_o,
                 yonlendir_adres_o, getir_durdur_o, dogru_sayac_o, yanlis_sayac_o,
                 e_guncelle, e_hatali, e_atladi, e_ps, e_adres, e_yadres,
                 (q.size() == DERINLIK), exp_dogru(), exp_yanlis());
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_dir_mispredict();
    test_jalr();
    test_signed();
    test_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
